// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer.
// Optional signed support is enabled with the SIGNED_MD_EN macro.
package md_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_DIVU  = 2'b01,
    MD_MULT  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/md_step.sv
// One iteration of shift-add multiply or restoring divide.
// Purely combinational; the sequencer registers the result.
module md_step
  import md_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] opnd_i,
  input  logic              div_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W:0] addend;
  logic [DATA_W:0] sum;
  logic [DATA_W:0] trial;

  always_comb begin
    addend = lo_i[0] ? {1'b0, opnd_i} : '0;
    sum    = {1'b0, hi_i} + addend;
    // top bit of hi shifts into the trial so no partial remainder is lost
    trial  = {hi_i, lo_i[DATA_W-1]} - {1'b0, opnd_i};
    if (div_i) begin
      if (!trial[DATA_W]) begin
        hi_o = trial[DATA_W-1:0];
        lo_o = {lo_i[DATA_W-2:0], 1'b1};
      end else begin
        hi_o = {hi_i[DATA_W-2:0], lo_i[DATA_W-1]};
        lo_o = {lo_i[DATA_W-2:0], 1'b0};
      end
    end else begin
      hi_o = sum[DATA_W:1];
      lo_o = {sum[0], lo_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multi-cycle MULT/DIV sequencer holding HI/LO until the next start.
// Define SIGNED_MD_EN to make ops MD_MULT/MD_DIV signed (adds a FIX cycle).
module mult_div_ctrl
  import md_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              div0_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic              div_q, div_d;
  logic              div0_q, div0_d;
  logic [DATA_W-1:0] step_hi, step_lo;
  logic [DATA_W-1:0] mag1, mag2;
  logic              op_div;

  assign op_div = op_i[0];

`ifdef SIGNED_MD_EN
  logic              sgn_q, sgn_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic              s1_neg, s2_neg;
  logic [2*DATA_W-1:0] prod_neg;

  assign s1_neg   = op_i[1] & src1_i[DATA_W-1];
  assign s2_neg   = op_i[1] & src2_i[DATA_W-1];
  assign mag1     = s1_neg ? -src1_i : src1_i;
  assign mag2     = s2_neg ? -src2_i : src2_i;
  assign prod_neg = -{hi_q, lo_q};
`else
  logic unused_op_sgn;

  assign unused_op_sgn = op_i[1];
  assign mag1          = src1_i;
  assign mag2          = src2_i;
`endif

  md_step #(.DATA_W(DATA_W)) u_step (
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .opnd_i (opnd_q),
    .div_i  (div_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    div0_d  = div0_q;
`ifdef SIGNED_MD_EN
    sgn_d    = sgn_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_i) begin
          cnt_d  = '0;
          div_d  = op_div;
          div0_d = 1'b0;
`ifdef SIGNED_MD_EN
          sgn_d    = op_i[1];
          neg_lo_d = s1_neg ^ s2_neg;
          neg_hi_d = op_div & s1_neg;
`endif
          if (op_div && (src2_i == '0)) begin
            state_d = S_DONE;
            hi_d    = src1_i;
            lo_d    = '1;
            div0_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            hi_d    = '0;
            lo_d    = op_div ? mag1 : mag2;
            opnd_d  = op_div ? mag2 : mag1;
          end
        end
      end
      S_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
`ifdef SIGNED_MD_EN
          state_d = sgn_q ? S_FIX : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef SIGNED_MD_EN
      S_FIX: begin
        state_d = S_DONE;
        if (!div_q) begin
          if (neg_lo_q) {hi_d, lo_d} = prod_neg;
        end else begin
          if (neg_lo_q) lo_d = -lo_q;
          if (neg_hi_q) hi_d = -hi_q;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      div0_q  <= 1'b0;
`ifdef SIGNED_MD_EN
      sgn_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      div0_q  <= div0_d;
`ifdef SIGNED_MD_EN
      sgn_q    <= sgn_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
`endif
    end
  end

  assign busy_o = (state_q == S_RUN) || (state_q == S_FIX);
  assign done_o = (state_q == S_DONE);
  assign div0_o = div0_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl (DATA_W=32).
// Follows SIGNED_MD_EN the same way as the RTL build.
module tb_mult_div_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic        busy_o, done_o, div0_o;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int passed = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          lat;
  } res_t;

  res_t sb[$];

  mult_div_ctrl #(.DATA_W(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .div0_o  (div0_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic res_t model(logic [1:0] op, logic [31:0] a,
                                 logic [31:0] b);
    res_t r;
    logic sgn;
    longint sa, sb_, q, m;
    longint unsigned p;
`ifdef SIGNED_MD_EN
    sgn = op[1];
`else
    sgn = 1'b0;
`endif
    r.div0 = 1'b0;
    r.lat  = sgn ? 33 : 32;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    if (op[0]) begin
      if (b == 0) begin
        r.hi = a; r.lo = '1; r.div0 = 1'b1; r.lat = 0;
      end else if (sgn) begin
        q = sa / sb_; m = sa % sb_;
        r.lo = q[31:0]; r.hi = m[31:0];
      end else begin
        r.lo = a / b; r.hi = a % b;
      end
    end else begin
      if (sgn) p = longint'(sa * sb_);
      else     p = {32'b0, a} * {32'b0, b};
      r.hi = p[63:32]; r.lo = p[31:0];
    end
    return r;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
    sb.push_back(model(op, a, b));
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic collect(output res_t got, output res_t exp,
                         output int busy_n);
    int lat = 0;
    busy_n = 0;
    while (!done_o && lat < 100) begin
      if (busy_o) busy_n++;
      @(posedge clk_i);
      #1 lat++;
    end
    got.hi = hi_o; got.lo = lo_o; got.div0 = div0_o; got.lat = lat;
    if (sb.size() > 0) exp = sb.pop_front();
    else begin
      exp = '0; exp.lat = -1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1 total++;
    if ({busy_o, done_o, div0_o, hi_o, lo_o} !== '0)
      $display("FAIL reset got b%0b d%0b z%0b hi=%h lo=%h want all 0",
               busy_o, done_o, div0_o, hi_o, lo_o);
    else passed++;
    @(negedge clk_i) rst_i = 1'b1;
  endtask

  task automatic test_multu();
    res_t g, e;
    int bn;
    issue(2'b00, 32'd7, 32'd6);
    collect(g, e, bn);
    total++;
    if (g.lat !== 32) $display("FAIL multu_lat got %0d want 32", g.lat);
    else passed++;
    total++;
    if (bn !== 32) $display("FAIL multu_busy got %0d want 32", bn);
    else passed++;
    total++;
    if ({g.hi, g.lo} !== {32'h0, 32'h2A})
      $display("FAIL multu_7x6 got %h_%h want 0_2a", g.hi, g.lo);
    else passed++;
    @(posedge clk_i);
    #1 total++;
    if ({done_o, busy_o} !== 2'b00)
      $display("FAIL done_pulse got d%0b b%0b want 0 0", done_o, busy_o);
    else passed++;
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect(g, e, bn);
    total++;
    if ({g.hi, g.lo} !== {e.hi, e.lo} || g.lo !== 32'h1)
      $display("FAIL multu_max got %h_%h want %h_%h",
               g.hi, g.lo, e.hi, e.lo);
    else passed++;
  endtask

  task automatic test_divu();
    res_t g, e;
    int bn;
    issue(2'b01, 32'd100, 32'd7);
    collect(g, e, bn);
    total++;
    if ({g.hi, g.lo, g.div0, g.lat} !== {32'd2, 32'd14, 1'b0, 32'd32})
      $display("FAIL divu_100_7 got hi=%0d lo=%0d z=%0b lat=%0d want 2 14 0 32",
               g.hi, g.lo, g.div0, g.lat);
    else passed++;
  endtask

  task automatic test_div0();
    res_t g, e;
    int bn;
    issue(2'b01, 32'd5, 32'd0);
    collect(g, e, bn);
    total++;
    if ({g.hi, g.lo, g.div0, g.lat} !== {32'd5, 32'hFFFF_FFFF, 1'b1, 32'd0})
      $display("FAIL div0 got hi=%h lo=%h z=%0b lat=%0d want 5 ffffffff 1 0",
               g.hi, g.lo, g.div0, g.lat);
    else passed++;
    issue(2'b00, 32'd2, 32'd3);
    total++;
    if ({div0_o, busy_o} !== 2'b01)
      $display("FAIL div0_clear got z%0b b%0b want z0 b1", div0_o, busy_o);
    else passed++;
    collect(g, e, bn);
    total++;
    if ({g.hi, g.lo, g.div0} !== {e.hi, e.lo, e.div0})
      $display("FAIL after_div0 got %h_%h want %h_%h", g.hi, g.lo, e.hi, e.lo);
    else passed++;
  endtask

  task automatic test_ignore_start();
    res_t g, e;
    int bn;
    int extra = 0;
    issue(2'b00, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b01; src1_i = 32'd99; src2_i = 32'd0;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    src1_i = 32'hDEAD_BEEF; src2_i = 32'h1;
    collect(g, e, bn);
    total++;
    if ({g.hi, g.lo, g.div0} !== {e.hi, e.lo, e.div0})
      $display("FAIL ignore_start got %h_%h z%0b want %h_%h z%0b",
               g.hi, g.lo, g.div0, e.hi, e.lo, e.div0);
    else passed++;
    repeat (4) begin
      @(posedge clk_i);
      #1 if (done_o || busy_o) extra++;
    end
    total++;
    if (extra !== 0) $display("FAIL ignore_queued got %0d want 0", extra);
    else passed++;
  endtask

  task automatic test_back_to_back();
    res_t g, e;
    int bn;
    issue(2'b01, 32'd1000, 32'd33);
    collect(g, e, bn);
    issue(2'b00, 32'd9, 32'd11);
    total++;
    if ({g.hi, g.lo} !== {e.hi, e.lo} || busy_o !== 1'b1)
      $display("FAIL b2b_first got %h_%h b%0b want %h_%h b1",
               g.hi, g.lo, busy_o, e.hi, e.lo);
    else passed++;
    collect(g, e, bn);
    total++;
    if ({g.hi, g.lo, g.lat} !== {32'd0, 32'd99, 32'd32})
      $display("FAIL b2b_second got %h_%h lat=%0d want 0_63 lat=32",
               g.hi, g.lo, g.lat);
    else passed++;
  endtask

  task automatic test_reset_abort();
    res_t g, e;
    int bn;
    int seen = 0;
    issue(2'b00, 32'd7, 32'd6);
    repeat (15) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1 total++;
    if ({busy_o, done_o, div0_o, hi_o, lo_o} !== '0)
      $display("FAIL abort_zero got b%0b d%0b hi=%h lo=%h want all 0",
               busy_o, done_o, hi_o, lo_o);
    else passed++;
    sb.delete();
    @(negedge clk_i) rst_i = 1'b1;
    repeat (40) begin
      @(posedge clk_i);
      #1 if (done_o || busy_o) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL abort_no_done got %0d want 0", seen);
    else passed++;
    issue(2'b00, 32'd3, 32'd4);
    collect(g, e, bn);
    total++;
    if ({g.hi, g.lo} !== {32'd0, 32'd12})
      $display("FAIL abort_fresh got %h_%h want 0_c", g.hi, g.lo);
    else passed++;
  endtask

  task automatic test_signed();
    res_t g, e;
    int bn;
    issue(2'b10, 32'hFFFF_FFF9, 32'd3);
    collect(g, e, bn);
`ifdef SIGNED_MD_EN
    total++;
    if ({g.hi, g.lo, g.lat} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'd33})
      $display("FAIL mult_neg got %h_%h lat=%0d want ffffffff_ffffffeb 33",
               g.hi, g.lo, g.lat);
    else passed++;
    issue(2'b11, 32'hFFFF_FFF9, 32'd2);
    collect(g, e, bn);
    total++;
    if ({g.hi, g.lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD})
      $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", g.hi, g.lo);
    else passed++;
`else
    total++;
    if ({g.hi, g.lo, g.lat} !== {32'h2, 32'hFFFF_FFEB, 32'd32})
      $display("FAIL op10_unsigned got %h_%h lat=%0d want 2_ffffffeb 32",
               g.hi, g.lo, g.lat);
    else passed++;
`endif
  endtask

  task automatic test_random();
    res_t g, e;
    int bn;
    logic [1:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (a == 32'h8000_0000) a = 32'h7FFF_0000;
      issue(op, a, b);
      collect(g, e, bn);
      total++;
      if ({g.hi, g.lo, g.div0, g.lat} !== {e.hi, e.lo, e.div0, e.lat})
        $display("FAIL rand%0d op=%0d a=%h b=%h got %h_%h lat=%0d want %h_%h lat=%0d",
                 i, op, a, b, g.hi, g.lo, g.lat, e.hi, e.lo, e.lat);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_divu();
    test_div0();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_signed();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
